// File: rtl/gray_conv_pkg.sv
// Shared constants and chunk-boundary helpers for the pipelined Gray/binary converter.
package gray_conv_pkg;

  localparam logic MODE_G2B = 1'b0;
  localparam logic MODE_B2G = 1'b1;

  function automatic int chunk_size(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

  // Highest bit resolved by stage s; negative when the stage has no bits left to resolve.
  function automatic int chunk_hi(input int s, input int width, input int stages);
    return width - 1 - s * chunk_size(width, stages);
  endfunction

  function automatic int chunk_lo(input int s, input int width, input int stages);
    int lo;
    lo = width - (s + 1) * chunk_size(width, stages);
    return (lo < 0) ? 0 : lo;
  endfunction

endpackage

// File: rtl/gray_conv_pipe_if.sv
// Valid/ready stream bundle for the converter: input side and output side.
interface gray_conv_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 4
);
  localparam int unsigned DW = WIDTH * LANES;

  logic          in_valid;
  logic          in_ready;
  logic          in_mode;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_mode;
  logic [DW-1:0] out_data;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_mode, out_data
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_mode, out_data
  );
endinterface

// File: rtl/gray_conv_stage.sv
// One converter pipeline stage: all lanes plus the stage valid bit.
// Gray->bin resolves one chunk of bits per stage; bin->gray is done entirely in stage 0.
module gray_conv_stage
  import gray_conv_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LANES  = 4,
  parameter int unsigned STAGES = 2,
  parameter int unsigned IDX    = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   advance,
  input  logic                   up_mode,
  input  logic [LANES*WIDTH-1:0] up_data,
  output logic                   v,
  output logic                   mode,
  output logic [LANES*WIDTH-1:0] data
);
  localparam int unsigned DW = LANES * WIDTH;
  localparam int HI = chunk_hi(int'(IDX), int'(WIDTH), int'(STAGES));
  localparam int LO = chunk_lo(int'(IDX), int'(WIDTH), int'(STAGES));

  logic [DW-1:0]    nxt_data;
  logic [WIDTH-1:0] ln;

  // Bits above HI are already binary, bits in [HI:LO] resolve here, lower bits stay raw gray.
  always_comb begin
    nxt_data = up_data;
    ln       = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      ln = up_data[k*WIDTH +: WIDTH];
      if (up_mode == MODE_B2G) begin
        if (IDX == 0) ln = ln ^ (ln >> 1);
      end else begin
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
          if (i <= HI && i >= LO) ln[i] = ln[i+1] ^ ln[i];
        end
      end
      nxt_data[k*WIDTH +: WIDTH] = ln;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v    <= 1'b0;
      mode <= MODE_G2B;
      data <= '0;
    end else if (load) begin
      v    <= 1'b1;
      mode <= up_mode;
      data <= nxt_data;
    end else if (advance) begin
      v    <= 1'b0;
    end
  end

endmodule

// File: rtl/gray_conv_pipe.sv
// Multi-lane pipelined Gray/binary converter: ready chain across the stages plus port mapping.
module gray_conv_pipe
  import gray_conv_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LANES  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  gray_conv_pipe_if.slave   bus
);
  localparam int unsigned DW = LANES * WIDTH;

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic [STAGES:0]   rdy;
  logic              mode_q  [STAGES];
  logic [DW-1:0]     data_q  [STAGES];
  logic              up_mode [STAGES];
  logic [DW-1:0]     up_data [STAGES];

  // rdy[k]: stage k can take a new entry; rdy[STAGES] is the downstream consumer.
  always_comb begin
    rdy  = '0;
    adv  = '0;
    load = '0;
    rdy[STAGES] = bus.out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      adv[k] = v[k] & rdy[k+1];
      rdy[k] = ~v[k] | adv[k];
    end
    load[0] = bus.in_valid & rdy[0] & rst_n;
    for (int k = 1; k < int'(STAGES); k++) begin
      load[k] = adv[k-1];
    end
  end

  for (genvar k = 0; k < int'(STAGES); k++) begin : stg
    if (k == 0) begin : g_head
      assign up_mode[k] = bus.in_mode;
      assign up_data[k] = bus.in_data;
    end else begin : g_link
      assign up_mode[k] = mode_q[k-1];
      assign up_data[k] = data_q[k-1];
    end

    gray_conv_stage #(
      .WIDTH  (WIDTH),
      .LANES  (LANES),
      .STAGES (STAGES),
      .IDX    (k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load[k]),
      .advance (adv[k]),
      .up_mode (up_mode[k]),
      .up_data (up_data[k]),
      .v       (v[k]),
      .mode    (mode_q[k]),
      .data    (data_q[k])
    );
  end

  assign bus.in_ready  = rdy[0] & rst_n;
  assign bus.out_valid = v[STAGES-1];
  assign bus.out_mode  = mode_q[STAGES-1];
  assign bus.out_data  = data_q[STAGES-1];

endmodule

// File: tb/tb_gray_conv_pipe.sv
// Directed bench for gray_conv_pipe: main 8x2x2 instance plus STAGES=1 and STAGES=8 single-lane corners.
module tb_gray_conv_pipe;
  import gray_conv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gray_conv_pipe_if #(.WIDTH(8), .LANES(2)) b0 ();
  gray_conv_pipe_if #(.WIDTH(8), .LANES(1)) b1 ();
  gray_conv_pipe_if #(.WIDTH(8), .LANES(1)) b2 ();

  gray_conv_pipe #(.WIDTH(8), .LANES(2), .STAGES(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  gray_conv_pipe #(.WIDTH(8), .LANES(1), .STAGES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  gray_conv_pipe #(.WIDTH(8), .LANES(1), .STAGES(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

  int n_checks = 0;
  int n_err    = 0;

  logic [15:0] s_data[$];
  logic        s_mode[$];
  logic [15:0] e_data[$];
  logic        e_mode[$];
  logic [15:0] g_data[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    s_data.delete(); s_mode.delete(); e_data.delete(); e_mode.delete(); g_data.delete();
  endtask

  task automatic push(input logic m, input logic [15:0] d, input logic [15:0] e);
    s_mode.push_back(m); s_data.push_back(d);
    e_mode.push_back(m); e_data.push_back(e);
  endtask

  // Drives the queued transactions into dut0 from index start and collects every result.
  task automatic run_stream(input int start, input bit rnd, input int budget, input bit chk,
                            output int cyc);
    int ni;
    int no;
    ni = start; no = 0; cyc = 0;
    while (no < s_data.size() && cyc < budget) begin
      if (ni < s_data.size()) begin
        b0.in_valid = 1'b1;
        b0.in_mode  = s_mode[ni];
        b0.in_data  = s_data[ni];
      end else begin
        b0.in_valid = 1'b0;
      end
      b0.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (b0.out_valid && b0.out_ready) begin
        g_data.push_back(b0.out_data);
        if (chk && no < e_data.size()) begin
          check("stream_data", 32'(b0.out_data), 32'(e_data[no]));
          check("stream_mode", 32'(b0.out_mode), 32'(e_mode[no]));
        end
        no++;
      end
      if (b0.in_valid && b0.in_ready) ni++;
      step();
      cyc++;
    end
    b0.in_valid  = 1'b0;
    b0.out_ready = 1'b1;
    check("stream_done", 32'(no), 32'(s_data.size()));
  endtask

  // Single-lane latency/result check on the corner instances (sel 1: STAGES=1, sel 2: STAGES=8).
  task automatic lat_test(input int sel, input int stages, input logic m,
                          input logic [7:0] d, input logic [7:0] e);
    int         cyc;
    logic       ov;
    logic       om;
    logic [7:0] od;
    logic       ir;
    if (sel == 1) begin
      b1.in_valid = 1'b1; b1.in_mode = m; b1.in_data = d; b1.out_ready = 1'b1;
    end else begin
      b2.in_valid = 1'b1; b2.in_mode = m; b2.in_data = d; b2.out_ready = 1'b1;
    end
    #1;
    ir = (sel == 1) ? b1.in_ready : b2.in_ready;
    check("corner_in_ready", 32'(ir), 32'(1));
    step();
    b1.in_valid = 1'b0;
    b2.in_valid = 1'b0;
    cyc = 1;
    ov = (sel == 1) ? b1.out_valid : b2.out_valid;
    while (!ov && cyc < 20) begin
      step();
      cyc++;
      ov = (sel == 1) ? b1.out_valid : b2.out_valid;
    end
    od = (sel == 1) ? b1.out_data : b2.out_data;
    om = (sel == 1) ? b1.out_mode : b2.out_mode;
    check("corner_latency", 32'(cyc), 32'(stages));
    check("corner_data", 32'(od), 32'(e));
    check("corner_mode", 32'(om), 32'(m));
    step();
  endtask

  initial begin
    int cyc;
    int acc;
    logic [15:0] tmp[$];

    rst_n = 1'b0;
    b0.in_valid = 1'b0; b0.in_mode = 1'b0; b0.in_data = '0; b0.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_mode = 1'b0; b1.in_data = '0; b1.out_ready = 1'b1;
    b2.in_valid = 1'b0; b2.in_mode = 1'b0; b2.in_data = '0; b2.out_ready = 1'b1;
    repeat (2) step();

    check("rst_out_valid", 32'(b0.out_valid), 32'(0));
    check("rst_out_data", 32'(b0.out_data), 32'(0));
    check("rst_out_mode", 32'(b0.out_mode), 32'(0));
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(b0.in_ready), 32'(1));
    step();

    // Single transactions: gray->bin then bin->gray, latency 2.
    clear_q();
    push(MODE_G2B, 16'h80C0, 16'hFF80);
    run_stream(0, 1'b0, 20, 1'b1, cyc);
    check("lat_g2b", 32'(cyc), 32'(3));
    clear_q();
    push(MODE_B2G, 16'hFF05, 16'h8007);
    run_stream(0, 1'b0, 20, 1'b1, cyc);
    check("lat_b2g", 32'(cyc), 32'(3));

    // Alternating modes back to back: 4 results in 4 consecutive cycles after the latency.
    clear_q();
    push(MODE_G2B, 16'h80C0, 16'hFF80);
    push(MODE_B2G, 16'hFF05, 16'h8007);
    push(MODE_G2B, 16'h010F, 16'h010A);
    push(MODE_B2G, 16'h800A, 16'hC00F);
    run_stream(0, 1'b0, 30, 1'b1, cyc);
    check("alt_no_bubble", 32'(cyc), 32'(6));

    // Backpressure: only two fit, head stays stable, then all four drain in order.
    clear_q();
    push(MODE_B2G, 16'h0201, 16'h0301);
    push(MODE_B2G, 16'h0403, 16'h0602);
    push(MODE_B2G, 16'h0807, 16'h0C04);
    push(MODE_B2G, 16'h2010, 16'h3018);
    b0.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      b0.in_valid = 1'b1;
      b0.in_mode  = s_mode[(acc < 4) ? acc : 3];
      b0.in_data  = s_data[(acc < 4) ? acc : 3];
      #1;
      if (b0.in_ready && acc < 4) acc++;
      step();
      if (c == 3) check("bp_hold_early", 32'(b0.out_data), 32'(16'h0301));
    end
    #1;
    check("bp_accepted", 32'(acc), 32'(2));
    check("bp_in_ready", 32'(b0.in_ready), 32'(0));
    check("bp_out_valid", 32'(b0.out_valid), 32'(1));
    check("bp_hold_data", 32'(b0.out_data), 32'(16'h0301));
    check("bp_hold_mode", 32'(b0.out_mode), 32'(1));
    run_stream(acc, 1'b0, 40, 1'b1, cyc);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_no_dup", 32'(b0.out_valid), 32'(0));
      step();
    end

    // Reset with two transactions in flight.
    b0.out_ready = 1'b0;
    b0.in_valid = 1'b1; b0.in_mode = MODE_G2B; b0.in_data = 16'h80C0;
    step();
    b0.in_mode = MODE_B2G; b0.in_data = 16'hFF05;
    step();
    b0.in_valid = 1'b0;
    check("rst_pre_valid", 32'(b0.out_valid), 32'(1));
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(b0.out_valid), 32'(0));
    check("rst_async_data", 32'(b0.out_data), 32'(0));
    #2;
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", 32'(b0.in_ready), 32'(1));
    b0.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("rst_no_stale", 32'(b0.out_valid), 32'(0));
    end

    // Exhaustive round trip with random downstream stalls; lane1 carries the complement.
    clear_q();
    for (int i = 0; i < 256; i++) push(MODE_B2G, {~8'(i), 8'(i)}, 16'h0000);
    run_stream(0, 1'b1, 4000, 1'b0, cyc);
    tmp = g_data;
    clear_q();
    for (int i = 0; i < tmp.size(); i++) push(MODE_G2B, tmp[i], {~8'(i), 8'(i)});
    run_stream(0, 1'b1, 4000, 1'b1, cyc);
    check("roundtrip_count", 32'(tmp.size()), 32'(256));

    // Corner configurations.
    lat_test(1, 1, MODE_G2B, 8'hB3, 8'hDD);
    lat_test(1, 1, MODE_B2G, 8'hB3, 8'hEA);
    lat_test(1, 1, MODE_G2B, 8'h80, 8'hFF);
    lat_test(2, 8, MODE_G2B, 8'hB3, 8'hDD);
    lat_test(2, 8, MODE_B2G, 8'hB3, 8'hEA);
    lat_test(2, 8, MODE_G2B, 8'h80, 8'hFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
